uart_rcv_control: RTL and testbench

- Sequencing controller for the UART receive shift register (8-bit, LSB-first, right-shifting, with Shift/SerIn/OE inputs).
- Synchronizes the serial line and detects start bits. Times bit centres from a clock-cycle counter and pulses Shift once per data bit. Checks the stop bit.
- Exposes ready/error status to the CPU bus and gates the shift register's output enable on bus reads.
- Sits between the RxD pin, the receive shift register and the UART bus-interface decode.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rcv_control.sv | 168 ++++++++++++++++
 tb/tb_uart_rcv_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, the
// controller's state record, default bit timing and data-bit count.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
    localparam int DATA_BITS            = 8;
    localparam int IDX_W                = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    // Sequencing state kept together so it can be probed as one record.
    typedef struct packed {
        state_e             state;
        logic [IDX_W-1:0]   bit_idx;
    } ctrl_t;

    // True when the given index is the last data bit of a frame.
    function automatic logic is_last_bit(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(DATA_BITS - 1);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous serial line. Both stages reset
// to 1 so an idle-high line never looks like a start bit out of reset.
module uart_sync2 (
    input  logic Clock,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw line through the two stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, asynchronously preset to the idle level.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rcv_control.sv
// Sequencing controller for the UART receive shift register.
// Detects start bits on the synchronized RxD, times bit centres with a
// cycle counter, pulses Shift once per data bit (LSB first), checks the
// stop bit and keeps the RxReady / FramingError status for the CPU bus.
// Build option: define UART_RCV_OVERRUN_EN to add the Overrun status flag.
//
// Bus side: there is no back-pressure. Read is a one-cycle strobe; RcvOE
// follows it combinationally, and status flags it clears drop on the next
// edge unless a new set lands on that same edge, in which case the set wins.
module uart_rcv_control
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic RxD,
    input  logic Read,
    output logic Shift,
    output logic SerIn,
    output logic RcvOE,
    output logic RxReady,
    output logic FramingError
`ifdef UART_RCV_OVERRUN_EN
    ,
    output logic Overrun
`endif
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic               rx_s;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shift_q, shift_d;
    logic               rx_ready_q, rx_ready_d;
    logic               fe_q, fe_d;
    logic               data_pulse;
    logic               stop_sample;
`ifdef UART_RCV_OVERRUN_EN
    logic               ovr_q, ovr_d;
`endif

    uart_sync2 u_sync (
        .Clock    (Clock),
        .Reset    (Reset),
        .async_in (RxD),
        .sync_out (rx_s)
    );

    // State register: sequencing state, bit timer and status flags.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ctrl_q     <= '{state: IDLE, bit_idx: '0};
            cnt_q      <= '0;
            shift_q    <= 1'b0;
            rx_ready_q <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RCV_OVERRUN_EN
            ovr_q      <= 1'b0;
`endif
        end else begin
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_ready_q <= rx_ready_d;
            fe_q       <= fe_d;
`ifdef UART_RCV_OVERRUN_EN
            ovr_q      <= ovr_d;
`endif
        end
    end

    // Next-state logic: frame sequencing and bit-centre timing.
    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        case (ctrl_q.state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    ctrl_d.state = START;
                end
            end
            START: begin
                // Re-check the line half a bit in to reject glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        ctrl_d.state = IDLE;
                    end else begin
                        ctrl_d.state   = DATA;
                        ctrl_d.bit_idx = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    ctrl_d.bit_idx = ctrl_q.bit_idx + 1'b1;
                    if (is_last_bit(ctrl_q.bit_idx)) begin
                        ctrl_d.state = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    ctrl_d.state = rx_s ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // A line held low must rise before a new start is accepted.
                cnt_d = '0;
                if (rx_s) begin
                    ctrl_d.state = IDLE;
                end
            end
            default: begin
                ctrl_d = '{state: IDLE, bit_idx: '0};
                cnt_d  = '0;
            end
        endcase
    end

    // Output logic: Shift pulse and bus status flags (set beats Read clear).
    always_comb begin
        data_pulse  = (ctrl_q.state == DATA) && (cnt_q == BIT_LAST);
        stop_sample = (ctrl_q.state == STOP) && (cnt_q == BIT_LAST);
        shift_d     = data_pulse;

        rx_ready_d = Read ? 1'b0 : rx_ready_q;
        if (stop_sample && rx_s) begin
            rx_ready_d = 1'b1;
        end

        fe_d = Read ? 1'b0 : fe_q;
        if (stop_sample && !rx_s) begin
            fe_d = 1'b1;
        end

`ifdef UART_RCV_OVERRUN_EN
        // A completed frame while the previous byte is still unread.
        ovr_d = Read ? 1'b0 : ovr_q;
        if (stop_sample && rx_ready_q && !Read) begin
            ovr_d = 1'b1;
        end
`endif
    end

    assign Shift        = shift_q;
    assign SerIn        = rx_s;
    assign RcvOE        = Read;
    assign RxReady      = rx_ready_q;
    assign FramingError = fe_q;
`ifdef UART_RCV_OVERRUN_EN
    assign Overrun      = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rcv_control.sv
// Bench for uart_rcv_control at 16 clocks per bit. Frames are driven on RxD
// bit by bit; a reference model tracks the received bytes and status flags
// frame by frame, and Shift pulses are captured with their cycle numbers.
// Timing reference: RxD falls just after edge c0; two synchronizer edges,
// one detect edge, 8 clocks to the half-bit check and 16 to the first
// bit centre put the first Shift-high cycle at c0+27, then every 16.
// Build option: UART_RCV_OVERRUN_EN adds the Overrun checks.
module tb_uart_rcv_control;

    localparam int CPB = 16;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic RxD   = 1'b1;
    logic Read  = 1'b0;
    logic Shift, SerIn, RcvOE, RxReady, FramingError;
`ifdef UART_RCV_OVERRUN_EN
    logic Overrun;
`endif

    uart_rcv_control #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .RxD          (RxD),
        .Read         (Read),
        .Shift        (Shift),
        .SerIn        (SerIn),
        .RcvOE        (RcvOE),
        .RxReady      (RxReady),
        .FramingError (FramingError)
`ifdef UART_RCV_OVERRUN_EN
        ,
        .Overrun      (Overrun)
`endif
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: bytes expected to be assembled from the Shift pulses.
    logic [7:0] exp_q[$];
    logic       pulse_bit_q[$];
    int         pulse_cyc_q[$];

    // Reference status flags.
    logic m_ready = 1'b0;
    logic m_fe    = 1'b0;
    logic m_ovr   = 1'b0;

    always @(negedge Clock) begin
        if (!Reset && Shift) begin
            pulse_bit_q.push_back(SerIn);
            pulse_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h need 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rdy"}, 32'(RxReady), 32'(m_ready));
        check({tag, "_fe"}, 32'(FramingError), 32'(m_fe));
`ifdef UART_RCV_OVERRUN_EN
        check({tag, "_ovr"}, 32'(Overrun), 32'(m_ovr));
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic clear_pulses();
        pulse_bit_q.delete();
        pulse_cyc_q.delete();
    endtask

    // One frame: start, 8 data bits LSB first, stop bit, optional low hold.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit rd_on_stop, input int hold_low);
        int         c0;
        logic       prev_ready;
        logic [7:0] rb;
        logic [7:0] want;
        clear_pulses();
        exp_q.push_back(b);
        RxD = 1'b0;
        c0  = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            tick(CPB);
        end
        RxD = stop;
        tick(10);                                   // now at c0+154
        prev_ready = m_ready;
        check("rdy_pre_stop", 32'(RxReady), 32'(m_ready));
        if (rd_on_stop) begin
            Read = 1'b1;
            check("oe_on_read", 32'(RcvOE), 32'd1);
        end
        tick(1);                                    // stop-sample edge c0+155
        Read = 1'b0;
        if (stop) m_ready = 1'b1;
        else if (rd_on_stop) m_ready = 1'b0;
        if (!stop) m_fe = 1'b1;
        else if (rd_on_stop) m_fe = 1'b0;
        if (prev_ready && !rd_on_stop) m_ovr = 1'b1;
        else if (rd_on_stop) m_ovr = 1'b0;
        check_flags("stop_edge");
        tick(5);
        if (hold_low > 0) tick(hold_low);
        RxD = 1'b1;
        tick(4 + int'($urandom_range(0, 6)));
        check("n_shift", 32'(pulse_bit_q.size()), 32'd8);
        if (pulse_bit_q.size() == 8) begin
            for (int k = 0; k < 8; k++) rb[k] = pulse_bit_q[k];
            want = exp_q.pop_front();
            check("rx_byte", 32'(rb), 32'(want));
            check("t_first", 32'(pulse_cyc_q[0] - c0), 32'd27);
            check("t_last", 32'(pulse_cyc_q[7] - c0), 32'(27 + 7 * CPB));
        end else begin
            exp_q.delete();
        end
        check_flags("frame_end");
    endtask

    task automatic bus_read();
        Read = 1'b1;
        check("oe_read_hi", 32'(RcvOE), 32'd1);
        tick(1);
        Read = 1'b0;
        check("oe_read_lo", 32'(RcvOE), 32'd0);
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
        check_flags("after_read");
    endtask

    task automatic glitch(input int low_clks);
        clear_pulses();
        RxD = 1'b0;
        tick(low_clks);
        RxD = 1'b1;
        tick(40);
        check("glitch_shift", 32'(pulse_bit_q.size()), 32'd0);
        check_flags("glitch");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        check("rst_shift", 32'(Shift), 32'd0);
        check("rst_serin", 32'(SerIn), 32'd1);
        check_flags("rst");
        Reset = 1'b0;
        tick(5);

        // Basic frame, glitch rejection, framing error with held-low line.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        bus_read();
        glitch(4);
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        bus_read();

        // Read landing on the stop-sample edge: set wins.
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        bus_read();

        // Reset during bit 4 aborts the frame.
        clear_pulses();
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            RxD = i[0];
            tick(CPB);
        end
        tick(8);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_shift", 32'(Shift), 32'd0);
        check("mid_rst_serin", 32'(SerIn), 32'd1);
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
        check_flags("mid_rst");
        RxD = 1'b1;
        tick(2);
        Reset = 1'b0;
        clear_pulses();
        tick(3 * CPB);
        check("post_rst_shift", 32'(pulse_bit_q.size()), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 0);

`ifdef UART_RCV_OVERRUN_EN
        bus_read();
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check("ovr_set", 32'(Overrun), 32'd1);
        bus_read();
`endif

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                glitch(int'($urandom_range(1, CPB / 2 - 2)));
            end else if (kind <= 2) begin
                bus_read();
            end else begin
                logic [7:0] b;
                logic       stop;
                b    = 8'($urandom_range(0, 255));
                stop = ($urandom_range(0, 4) != 0);
                send_frame(b, stop, ($urandom_range(0, 5) == 0),
                           stop ? 0 : int'($urandom_range(0, 40)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
